// File: rtl/aha_clk_en_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aha_clk_en_pkg
//  Purpose  : Shared selection codes and FSM states for the clock-enable selector
//  Revision : 1.0
// ============================================================================
package aha_clk_en_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_BY1     = 3'd0;
    localparam logic [SEL_W-1:0] SEL_BY2     = 3'd1;
    localparam logic [SEL_W-1:0] SEL_BY4     = 3'd2;
    localparam logic [SEL_W-1:0] SEL_BY8     = 3'd3;
    localparam logic [SEL_W-1:0] SEL_BY16    = 3'd4;
    localparam logic [SEL_W-1:0] SEL_BY32    = 3'd5;
    localparam logic [SEL_W-1:0] SEL_OFF     = 3'd6;
    localparam logic [SEL_W-1:0] SEL_INVALID = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/aha_clk_en_mux.sv
`default_nettype none
// ============================================================================
//  Module   : aha_clk_en_mux
//  Purpose  : Combinational pick of one divided enable from the selection code
//  Revision : 1.0
// ============================================================================
module aha_clk_en_mux
    import aha_clk_en_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             by2_en,
    input  logic             by4_en,
    input  logic             by8_en,
    input  logic             by16_en,
    input  logic             by32_en,
    output logic             clken
);

    always_comb begin
        clken = 1'b0;
        case (sel)
            SEL_BY1:  clken = 1'b1;
            SEL_BY2:  clken = by2_en;
            SEL_BY4:  clken = by4_en;
            SEL_BY8:  clken = by8_en;
            SEL_BY16: clken = by16_en;
            SEL_BY32: clken = by32_en;
            default:  clken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/aha_clk_en_selector.sv
`default_nettype none
// ============================================================================
//  Module   : aha_clk_en_selector
//  Purpose  : Per-domain clock-enable selector with handshaked, aligned switching
//  Revision : 1.0
// ============================================================================
module aha_clk_en_selector
    import aha_clk_en_pkg::*;
#(
    parameter logic [SEL_W-1:0] RESET_SEL = 3'd0,
    parameter int               TIMEOUT   = 64
)(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             By2CLKEN,
    input  logic             By4CLKEN,
    input  logic             By8CLKEN,
    input  logic             By16CLKEN,
    input  logic             By32CLKEN,
    input  logic             SEL_REQ,
    input  logic [SEL_W-1:0] SEL_VAL,
    output logic             SEL_ACK,
    output logic             SEL_ERR,
    output logic             BUSY,
    output logic [SEL_W-1:0] CUR_SEL,
    output logic             CLKEN
);

    localparam logic [6:0] TIMEOUT_LAST = 7'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] req_q;
    logic [SEL_W-1:0] cur_sel_q;
    logic             err_q, err_d;
    logic [6:0]       timer_q;
    logic             run_q;
    logic             load_req, load_sel, timer_clr;
    logic             mux_en;

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        load_req  = 1'b0;
        load_sel  = 1'b0;
        timer_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (SEL_REQ) begin
                    load_req = 1'b1;
                    if (SEL_VAL == SEL_INVALID) begin
                        state_d = ST_ACK;
                        err_d   = 1'b1;
                    end else if (SEL_VAL == cur_sel_q) begin
                        state_d = ST_ACK;
                        err_d   = 1'b0;
                    end else begin
                        state_d   = ST_ALIGN;
                        timer_clr = 1'b1;
                    end
                end
            end
            // By32 marks the point where every divided enable pulses together
            ST_ALIGN: begin
                if (By32CLKEN) begin
                    load_sel = 1'b1;
                    state_d  = ST_ACK;
                    err_d    = 1'b0;
                end else if (timer_q >= TIMEOUT_LAST) begin
                    state_d = ST_ACK;
                    err_d   = 1'b1;
                end
            end
            ST_ACK: begin
                if (!SEL_REQ) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            err_q     <= 1'b0;
            req_q     <= RESET_SEL;
            cur_sel_q <= RESET_SEL;
            timer_q   <= 7'd0;
            run_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            run_q   <= 1'b1;
            if (load_req) begin
                req_q <= SEL_VAL;
            end
            if (load_sel) begin
                cur_sel_q <= req_q;
            end
            if (timer_clr) begin
                timer_q <= 7'd0;
            end else if (state_q == ST_ALIGN && timer_q != 7'h7f) begin
                timer_q <= timer_q + 7'd1;
            end
        end
    end

    aha_clk_en_mux u_mux (
        .sel     (cur_sel_q),
        .by2_en  (By2CLKEN),
        .by4_en  (By4CLKEN),
        .by8_en  (By8CLKEN),
        .by16_en (By16CLKEN),
        .by32_en (By32CLKEN),
        .clken   (mux_en)
    );

    assign SEL_ACK = (state_q == ST_ACK);
    assign SEL_ERR = err_q;
    assign BUSY    = (state_q != ST_IDLE);
    assign CUR_SEL = cur_sel_q;
    assign CLKEN   = run_q & mux_en;

endmodule
`default_nettype wire
